pin_input_filter: RTL

Per-pin input conditioning stage that sits between the board input pads and the pinmux, which consumes sonata_in_pins_t / sonata_inout_pins_t vectors. It synchronises every asynchronous pad input into the system clock domain. It then applies a runtime-configurable, per-pin glitch filter and emits per-pin rise, fall and glitch-rejected pulses. The top level instantiates it twice: Width=IN_PIN_NUM for input pins and Width=INOUT_PIN_NUM for the input side of inout pins.

---
 rtl/pin_input_filter_pkg.sv | 17 +
 rtl/pin_input_filter_bit.sv | 83 ++++++++
 rtl/pin_input_filter.sv | 45 ++++
 3 files changed

// File: rtl/pin_input_filter_pkg.sv
// Shared definitions for the pad input conditioning stage.
//   PIN_FILTER_CNT_WIDTH : default width of the per-pin stability counter
//   filt_mode_e          : per-pin operating mode (synchroniser only / glitch filter)
package pin_input_filter_pkg;

    localparam int PIN_FILTER_CNT_WIDTH = 8;

    typedef enum logic {
        MODE_BYPASS = 1'b0,
        MODE_FILTER = 1'b1
    } filt_mode_e;

    function automatic filt_mode_e mode_of(input logic en);
        return en ? MODE_FILTER : MODE_BYPASS;
    endfunction

endpackage

// File: rtl/pin_input_filter_bit.sv
// One pin: 2-flop synchroniser, stability counter and registered edge/glitch pulses.
//   clk_i, rst_i   : system clock, async active-high reset
//   pin_i          : raw asynchronous pad input
//   filter_en_i    : 1 = glitch filter, 0 = synchroniser only
//   thresh_i       : stability threshold (change must persist thresh_i+1 cycles)
//   pin_o          : conditioned pin value
//   rise_o/fall_o  : one-cycle pulses coincident with a pin_o transition
//   glitch_o       : one-cycle pulse when a pending change is abandoned
module pin_input_filter_bit
    import pin_input_filter_pkg::*;
#(
    parameter int   CntWidth = PIN_FILTER_CNT_WIDTH,
    parameter logic ResetVal = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pin_i,
    input  logic                filter_en_i,
    input  logic [CntWidth-1:0] thresh_i,
    output logic                pin_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                glitch_o
);

    logic                r_s1, r_s2, r_pin;
    logic                r_rise, r_fall, r_glitch;
    logic [CntWidth-1:0] r_cnt;

    logic                w_next_pin;
    logic [CntWidth-1:0] w_next_cnt;
    logic                w_next_glitch;

    always_comb begin
        w_next_pin    = r_pin;
        w_next_cnt    = '0;
        w_next_glitch = 1'b0;
        case (mode_of(filter_en_i))
            MODE_BYPASS: begin
                // Leaving filter mode drops any pending count silently.
                w_next_pin = r_s2;
            end
            MODE_FILTER: begin
                if (r_s2 == r_pin) begin
                    w_next_glitch = (r_cnt != '0);
                end else if (r_cnt >= thresh_i) begin
                    // >= so that lowering thresh_i below an in-flight count commits at once.
                    w_next_pin = r_s2;
                end else begin
                    // Bounded by thresh_i, which cannot exceed the counter range: no wrap.
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: w_next_pin = r_s2;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1     <= ResetVal;
            r_s2     <= ResetVal;
            r_pin    <= ResetVal;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_s1     <= pin_i;
            r_s2     <= r_s1;
            r_pin    <= w_next_pin;
            r_cnt    <= w_next_cnt;
            r_rise   <= w_next_pin & ~r_pin;
            r_fall   <= ~w_next_pin & r_pin;
            r_glitch <= w_next_glitch;
        end
    end

    assign pin_o    = r_pin;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign glitch_o = r_glitch;

endmodule

// File: rtl/pin_input_filter.sv
// Per-pin input conditioning between the board pads and the pinmux.
// Each pin is synchronised into clk_i and optionally glitch filtered.
//   clk_i, rst_i  : system clock, async active-high reset
//   pins_i        : raw asynchronous pad inputs [Width]
//   filter_en_i   : per-pin filter enable, 0 = synchroniser only [Width]
//   thresh_i      : shared stability threshold [CntWidth], quasi-static
//   pins_o        : conditioned pin values [Width]
//   rise_o/fall_o : one-cycle edge pulses aligned with pins_o changes [Width]
//   glitch_o      : one-cycle pulse per abandoned pending change [Width]
module pin_input_filter
    import pin_input_filter_pkg::*;
#(
    parameter int               Width    = 5,
    parameter int               CntWidth = PIN_FILTER_CNT_WIDTH,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    pins_i,
    input  logic [Width-1:0]    filter_en_i,
    input  logic [CntWidth-1:0] thresh_i,
    output logic [Width-1:0]    pins_o,
    output logic [Width-1:0]    rise_o,
    output logic [Width-1:0]    fall_o,
    output logic [Width-1:0]    glitch_o
);

    for (genvar g = 0; g < Width; g++) begin : g_pin
        pin_input_filter_bit #(
            .CntWidth (CntWidth),
            .ResetVal (ResetVal[g])
        ) u_bit (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .pin_i       (pins_i[g]),
            .filter_en_i (filter_en_i[g]),
            .thresh_i    (thresh_i),
            .pin_o       (pins_o[g]),
            .rise_o      (rise_o[g]),
            .fall_o      (fall_o[g]),
            .glitch_o    (glitch_o[g])
        );
    end

endmodule
